// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
//   Shared definitions for the memory-match game: board geometry, the guess
//   capture FSM state type and the row/column -> tile index mapping.
//   Used by the guess capture block, the guess checker and the board generator.
// -----------------------------------------------------------------------------
package mm_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned N    = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    OFFER   = 2'd2,
    RELEASE = 2'd3
  } gc_state_e;

  // Tile numbering is row-major: bit (row*cols + col) of every tile vector.
  function automatic int unsigned tile_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols = COLS);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// -----------------------------------------------------------------------------
// sync_rise
//   Two-flop synchroniser for an asynchronous key level followed by an edge
//   register, giving a clean synchronous level and a 1-cycle rising-edge pulse.
// Ports
//   clk     in   clock
//   reset   in   synchronous, active-low reset
//   d       in   asynchronous level (key held = 1)
//   q_sync  out  synchronised level (second flop)
//   rise    out  1 for one cycle when q_sync goes 0 -> 1
// -----------------------------------------------------------------------------
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_sync,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign q_sync = r_s2;
  assign rise   = r_s2 & ~r_s3;

endmodule

// File: rtl/guess_capture.sv
// -----------------------------------------------------------------------------
// guess_capture
//   Producer side of the guess interface. Converts the row/column switch
//   selection plus a submit key press into a one-hot tile guess offered on a
//   valid/ready handshake. Out-of-range coordinates and tiles already guessed
//   this round are rejected with a 1-cycle pulse. One guess per key press.
// Ports
//   clk            in   clock
//   reset          in   synchronous, active-low reset
//   enable         in   game is in the guess phase
//   clear          in   1-cycle pulse: new round, zero guessed_mask
//   row_sel        in   selected row (static switches)
//   col_sel        in   selected column (static switches)
//   submit         in   asynchronous key level, high while held
//   guess_ready    in   checker accepts the offered guess this cycle
//   guess_valid    out  guess offered (registered)
//   guess          out  one-hot tile guess, zero while guess_valid = 0
//   guessed_mask   out  tiles already transferred this round
//   dup_pulse      out  1-cycle: submitted tile was already guessed
//   invalid_pulse  out  1-cycle: row_sel >= ROWS or col_sel >= COLS
// -----------------------------------------------------------------------------
module guess_capture #(
  parameter int unsigned ROWS  = mm_pkg::ROWS,
  parameter int unsigned COLS  = mm_pkg::COLS,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned COL_W = 2,
  parameter int unsigned N     = ROWS * COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [ROW_W-1:0] row_sel,
  input  logic [COL_W-1:0] col_sel,
  input  logic             submit,
  input  logic             guess_ready,
  output logic             guess_valid,
  output logic [N-1:0]     guess,
  output logic [N-1:0]     guessed_mask,
  output logic             dup_pulse,
  output logic             invalid_pulse
);

  import mm_pkg::*;

  // One spare bit so the largest possible row*COLS+col never wraps back into
  // the legal tile range.
  localparam int unsigned IDX_W = $clog2(N) + 1;

  // ---------------------------------------------------------------------------
  // Submit key: synchronise and edge-detect
  // ---------------------------------------------------------------------------
  logic w_sub_level;
  logic w_sub_rise;

  sync_rise u_sync_submit (
    .clk    (clk),
    .reset  (reset),
    .d      (submit),
    .q_sync (w_sub_level),
    .rise   (w_sub_rise)
  );

  // ---------------------------------------------------------------------------
  // Coordinate decode
  // ---------------------------------------------------------------------------
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [N-1:0]     w_onehot;
  logic             w_already;

  assign w_in_range = (32'(row_sel) < ROWS) && (32'(col_sel) < COLS);
  assign w_idx      = IDX_W'(tile_idx(32'(row_sel), 32'(col_sel), COLS));
  // An out-of-range index shifts the bit off the top; it is never used then.
  assign w_onehot   = N'(1) << w_idx;
  assign w_already  = |(guessed_mask & w_onehot);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  gc_state_e    r_state;
  logic         r_guess_valid;
  logic [N-1:0] r_guess;
  logic [N-1:0] r_guessed_mask;
  logic         r_dup_pulse;
  logic         r_invalid_pulse;

  gc_state_e    w_state_n;
  logic         w_guess_valid_n;
  logic [N-1:0] w_guess_n;
  logic [N-1:0] w_guessed_mask_n;
  logic         w_dup_pulse_n;
  logic         w_invalid_pulse_n;

  // NOTE: the reset here is synchronous (sampled on the clock edge only), so it
  // sits inside the posedge-only always_ff rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_guess_valid   <= 1'b0;
      r_guess         <= '0;
      r_guessed_mask  <= '0;
      r_dup_pulse     <= 1'b0;
      r_invalid_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_guess_valid   <= w_guess_valid_n;
      r_guess         <= w_guess_n;
      r_guessed_mask  <= w_guessed_mask_n;
      r_dup_pulse     <= w_dup_pulse_n;
      r_invalid_pulse <= w_invalid_pulse_n;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_n         = r_state;
    w_guess_valid_n   = r_guess_valid;
    w_guess_n         = r_guess;
    w_guessed_mask_n  = r_guessed_mask;
    w_dup_pulse_n     = 1'b0;
    w_invalid_pulse_n = 1'b0;

    if (!enable) begin
      // Leaving the guess phase withdraws any offer without transferring it.
      w_state_n       = IDLE;
      w_guess_valid_n = 1'b0;
      w_guess_n       = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_n = ARMED;
        end

        ARMED: begin
          if (w_sub_rise) begin
            if (!w_in_range) begin
              w_invalid_pulse_n = 1'b1;
              w_state_n         = RELEASE;
            end else if (w_already) begin
              w_dup_pulse_n = 1'b1;
              w_state_n     = RELEASE;
            end else begin
              // The tile is latched here; later switch changes do not matter.
              w_guess_n       = w_onehot;
              w_guess_valid_n = 1'b1;
              w_state_n       = OFFER;
            end
          end
        end

        OFFER: begin
          if (r_guess_valid && guess_ready) begin
            w_guessed_mask_n = r_guessed_mask | r_guess;
            w_guess_valid_n  = 1'b0;
            w_guess_n        = '0;
            // Key still held: wait for release so one press gives one guess.
            w_state_n        = w_sub_level ? RELEASE : ARMED;
          end
        end

        RELEASE: begin
          if (!w_sub_level) begin
            w_state_n = ARMED;
          end
        end

        default: begin
          w_state_n       = IDLE;
          w_guess_valid_n = 1'b0;
          w_guess_n       = '0;
        end
      endcase
    end

    // A new round overrides any transfer landing on the same edge.
    if (clear) begin
      w_guessed_mask_n = '0;
    end
  end

  assign guess_valid   = r_guess_valid;
  assign guess         = r_guess;
  assign guessed_mask  = r_guessed_mask;
  assign dup_pulse     = r_dup_pulse;
  assign invalid_pulse = r_invalid_pulse;

endmodule

// File: tb/tb_guess_capture.sv
// -----------------------------------------------------------------------------
// tb_guess_capture
//   Self-checking bench for guess_capture. A 4x4 instance and a 3-row instance
//   share all stimulus; the 3-row build sees row 3 as out of range. Expected
//   values come from a tile-set model of the round (which tiles have been
//   transferred) and the press-to-offer timing of the interface.
// -----------------------------------------------------------------------------
module tb_guess_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [1:0]  row_sel;
  logic [1:0]  col_sel;
  logic        submit;
  logic        guess_ready;

  logic        guess_valid;
  logic [15:0] guess;
  logic [15:0] guessed_mask;
  logic        dup_pulse;
  logic        invalid_pulse;

  logic        guess_valid3;
  logic [11:0] guess3;
  logic [11:0] guessed_mask3;
  logic        dup_pulse3;
  logic        invalid_pulse3;

  guess_capture dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .row_sel       (row_sel),
    .col_sel       (col_sel),
    .submit        (submit),
    .guess_ready   (guess_ready),
    .guess_valid   (guess_valid),
    .guess         (guess),
    .guessed_mask  (guessed_mask),
    .dup_pulse     (dup_pulse),
    .invalid_pulse (invalid_pulse)
  );

  guess_capture #(.ROWS(3), .COLS(4), .ROW_W(2), .COL_W(2), .N(12)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .row_sel       (row_sel),
    .col_sel       (col_sel),
    .submit        (submit),
    .guess_ready   (guess_ready),
    .guess_valid   (guess_valid3),
    .guess         (guess3),
    .guessed_mask  (guessed_mask3),
    .dup_pulse     (dup_pulse3),
    .invalid_pulse (invalid_pulse3)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  // Set of tiles transferred this round (model of guessed_mask).
  logic [15:0] m_mask   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nothing offered, no pulses, masks equal to the model round set.
  task automatic check_idle(input string tag);
    check({tag, ".valid"},  32'(guess_valid),    0);
    check({tag, ".guess"},  32'(guess),          0);
    check({tag, ".dup"},    32'(dup_pulse),      0);
    check({tag, ".inv"},    32'(invalid_pulse),  0);
    check({tag, ".mask"},   32'(guessed_mask),   32'(m_mask));
    check({tag, ".valid3"}, 32'(guess_valid3),   0);
    check({tag, ".dup3"},   32'(dup_pulse3),     0);
    check({tag, ".inv3"},   32'(invalid_pulse3), 0);
    check({tag, ".mask3"},  32'(guessed_mask3),  32'(m_mask[11:0]));
  endtask

  // One complete key press on tile (r,c). delay = extra offer cycles with
  // ready low (0 = ready already high in the first valid cycle), hold = extra
  // cycles the key stays down after the transfer.
  task automatic press(input int r, input int c, input int delay, input int hold, input bit toggle);
    int          idx;
    logic [15:0] oh;
    bit          is_dup;
    bit          bad3;
    idx    = r * 4 + c;
    oh     = 16'h1 << idx;
    is_dup = m_mask[idx];
    bad3   = (r >= 3);

    row_sel     = 2'(r);
    col_sel     = 2'(c);
    guess_ready = 1'b0;
    submit      = 1'b1;
    step(); check_idle("sync1");
    step(); check_idle("sync2");
    if (!is_dup && delay == 0) guess_ready = 1'b1;
    step();

    if (is_dup) begin
      check("dup.pulse",  32'(dup_pulse),   1);
      check("dup.valid",  32'(guess_valid), 0);
      check("dup.mask",   32'(guessed_mask), 32'(m_mask));
      if (bad3) check("inv3.pulse", 32'(invalid_pulse3), 1);
      else      check("dup3.pulse", 32'(dup_pulse3),     1);
      step();
      check_idle("dup.after");
    end else begin
      check("offer.valid", 32'(guess_valid), 1);
      check("offer.guess", 32'(guess),       32'(oh));
      check("offer.dup",   32'(dup_pulse),   0);
      if (bad3) begin
        check("inv3.pulse",  32'(invalid_pulse3), 1);
        check("inv3.valid",  32'(guess_valid3),   0);
      end else begin
        check("offer3.valid", 32'(guess_valid3), 1);
        check("offer3.guess", 32'(guess3),       32'(oh[11:0]));
      end
      for (int i = 0; i < delay; i++) begin
        if (toggle) begin
          row_sel = 2'($urandom);
          col_sel = 2'($urandom);
        end
        step();
        check("hold.valid", 32'(guess_valid),  1);
        check("hold.guess", 32'(guess),        32'(oh));
        check("hold.mask",  32'(guessed_mask), 32'(m_mask));
        check("hold.inv3",  32'(invalid_pulse3), 0);
      end
      guess_ready = 1'b1;
      step();
      guess_ready = 1'b0;
      m_mask = m_mask | oh;
      check_idle("xfer");
      for (int i = 0; i < hold; i++) begin
        step();
        check_idle("keyheld");
      end
    end

    submit      = 1'b0;
    // Ready with nothing offered must be ignored.
    guess_ready = 1'($urandom);
    repeat (4) step();
    guess_ready = 1'b0;
    check_idle("released");
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    row_sel     = '0;
    col_sel     = '0;
    submit      = 1'b0;
    guess_ready = 1'b0;

    repeat (2) step();
    check_idle("reset");
    reset  = 1'b1;
    enable = 1'b1;
    step();
    check_idle("enabled");

    // Slow checker with switch noise during the offer, then a same-cycle accept.
    press(1, 2, 5, 0, 1'b1);
    check("t1.mask", 32'(guessed_mask), 32'h0040);
    press(0, 0, 0, 0, 1'b0);
    // Repeat of a transferred tile.
    press(1, 2, 0, 0, 1'b0);
    // Row 3: legal on 4x4, out of range on the 3-row build.
    press(3, 1, 1, 0, 1'b0);
    // Key held long after the transfer gives exactly one guess.
    press(2, 2, 0, 20, 1'b0);

    // Enable dropped during an offer: no transfer.
    row_sel = 2'd0;
    col_sel = 2'd3;
    submit  = 1'b1;
    repeat (3) step();
    check("en.valid", 32'(guess_valid), 1);
    check("en.guess", 32'(guess),       32'h0008);
    enable = 1'b0;
    step();
    check_idle("en.drop");
    enable = 1'b1;
    step();
    submit = 1'b0;
    repeat (4) step();
    check_idle("en.back");

    // Clear and transfer on the same edge: clear wins.
    submit = 1'b1;
    repeat (3) step();
    check("clr.valid", 32'(guess_valid), 1);
    guess_ready = 1'b1;
    clear       = 1'b1;
    step();
    guess_ready = 1'b0;
    clear       = 1'b0;
    m_mask      = '0;
    check_idle("clr.xfer");
    submit = 1'b0;
    repeat (4) step();

    // Randomised presses across rounds.
    for (int ep = 0; ep < 60; ep++) begin
      if (ep % 15 == 14) begin
        clear = 1'b1;
        step();
        clear  = 1'b0;
        m_mask = '0;
        check_idle("clear");
      end
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
